// File: rtl/xdisp_ctrl.sv
// Seven-segment display controller: signed write -> sign + 3 BCD digits, then continuous 4-digit scan.
// Latency: 11 cycles write-to-shadow (1 on overflow); writes never stall and always restart the conversion.
module xdisp_ctrl #(
    parameter int DATA_W      = 32,
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [7:0]        Disp,
    output logic [3:0]        Disp_sel
);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    state_t      state, state_nxt;
    logic        wr;
    logic [15:0] din16, mag_in;
    logic        mag_ovf;
    logic        busy, load_shadow;

    logic        sgn, ovf;
    logic [9:0]  bin;
    logic [11:0] bcd, bcd_adj;
    logic [3:0]  step;

    logic        sh_sgn, sh_ovf;
    logic [3:0]  sh_h, sh_t, sh_u;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [7:0]       seg_nxt;
    logic [DATA_W-17:0] unused_hi;

    assign unused_hi = data_in[DATA_W-1:16];
    assign wr        = sel & we;
    assign din16     = data_in[15:0];
    assign mag_in    = din16[15] ? (~din16 + 16'd1) : din16;
    // -32768 negates to 16'h8000, which lands in the overflow branch naturally
    assign mag_ovf   = mag_in > 16'd999;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (wr) begin
            state_nxt = mag_ovf ? LOAD : CONV;
        end else begin
            case (state)
                CONV:    if (step == 4'd9) state_nxt = LOAD;
                LOAD:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A write landing in LOAD supersedes the finished conversion
    always_comb begin
        busy        = (state != IDLE);
        load_shadow = (state == LOAD) && !wr;
    end

    assign data_out = {{(DATA_W-2){1'b0}}, ovf, busy};

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sgn  <= 1'b0;
            ovf  <= 1'b0;
            bin  <= '0;
            bcd  <= '0;
            step <= '0;
        end else if (wr) begin
            sgn  <= din16[15];
            ovf  <= mag_ovf;
            bin  <= mag_in[9:0];
            bcd  <= '0;
            step <= '0;
        end else if (state == CONV) begin
            {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
            step       <= step + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_sgn <= 1'b0;
            sh_ovf <= 1'b0;
            sh_h   <= '0;
            sh_t   <= '0;
            sh_u   <= '0;
        end else if (load_shadow) begin
            sh_sgn <= sgn;
            sh_ovf <= ovf;
            sh_h   <= bcd[11:8];
            sh_t   <= bcd[7:4];
            sh_u   <= bcd[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        seg_nxt = 8'hFF;
        if (sh_ovf) begin
            seg_nxt = 8'hBF;
        end else begin
            case (idx)
                2'd0: seg_nxt = seg7(sh_u);
                2'd1: seg_nxt = (sh_h == 4'd0 && sh_t == 4'd0) ? 8'hFF : seg7(sh_t);
                2'd2: seg_nxt = (sh_h == 4'd0) ? 8'hFF : seg7(sh_h);
                default: seg_nxt = sh_sgn ? 8'hBF : 8'hFF;
            endcase
        end
    end

    // Select and segments registered together so they always refer to the same digit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Disp     <= 8'hC0;
            Disp_sel <= 4'b1110;
        end else begin
            Disp     <= seg_nxt;
            Disp_sel <= ~(4'b0001 << idx);
        end
    end

endmodule

// File: tb/tb_xdisp_ctrl.sv
// Bench for xdisp_ctrl with a 4-cycle refresh; expected values queued at stimulus time, popped at observation.
module tb_xdisp_ctrl;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sel = 1'b0;
    logic              we  = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_out;
    logic [7:0]        Disp;
    logic [3:0]        Disp_sel;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    xdisp_ctrl #(.DATA_W(DATA_W), .REFRESH_DIV(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .data_in(data_in),
        .data_out(data_out), .Disp(Disp), .Disp_sel(Disp_sel)
    );

    always #5 clk = ~clk;

    // Called at a negedge; the write is sampled at the following posedge.
    task automatic write_val(input logic [15:0] v);
        sel = 1'b1; we = 1'b1; data_in = {16'h0, v};
        @(negedge clk);
        sel = 1'b0; we = 1'b0; data_in = '0;
    endtask

    task automatic push4(input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
        exp_q.push_back({24'h0, d0}); exp_q.push_back({24'h0, d1});
        exp_q.push_back({24'h0, d2}); exp_q.push_back({24'h0, d3});
    endtask

    task automatic check_busy_len(input string name);
        int n = 0;
        logic [31:0] e = exp_q.pop_front();
        while (data_out[0] && n < 50) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n !== int'(e)) begin
            miscompares++;
            $display("FAIL %s busy cycles got %0d expected %0d", name, n, e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (data_out[0] && n < 50) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic scan(input string name);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] want_sel = ~(4'b0001 << k);
            logic [31:0] e = exp_q.pop_front();
            int n = 0;
            while (Disp_sel !== want_sel && n < 40) begin
                n++;
                @(negedge clk);
            end
            vectors++;
            if (Disp_sel !== want_sel) begin
                miscompares++;
                $display("FAIL %s digit%0d select timeout got %b expected %b", name, k, Disp_sel, want_sel);
            end else if (Disp !== e[7:0]) begin
                miscompares++;
                $display("FAIL %s digit%0d Disp got %h expected %h", name, k, Disp, e[7:0]);
            end
        end
    endtask

    task automatic check_dout(input string name);
        logic [31:0] e = exp_q.pop_front();
        vectors++;
        if (data_out !== e) begin
            miscompares++;
            $display("FAIL %s data_out got %h expected %h", name, data_out, e);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if (Disp_sel !== 4'b1110 || Disp !== 8'hC0 || data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL %s got sel=%b disp=%h dout=%h expected sel=1110 disp=c0 dout=0",
                     name, Disp_sel, Disp, data_out);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        check_reset_outputs("reset_initial");
        rst = 1'b1;
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset_async");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_reset_outputs("reset_hold");
        end
    endtask

    task automatic test_negative();
        write_val(16'hFFF1);
        exp_q.push_back(32'd11);
        check_busy_len("neg15");
        exp_q.push_back(32'h0);
        check_dout("neg15_status");
        @(negedge clk);
        push4(8'h92, 8'hF9, 8'hFF, 8'hBF);
        scan("neg15");
    endtask

    task automatic test_limits();
        write_val(16'd999);
        wait_idle();
        push4(8'h90, 8'h90, 8'h90, 8'hFF);
        scan("pos999");
        @(negedge clk);
        write_val(16'hFC18);
        exp_q.push_back(32'd1);
        check_busy_len("neg1000");
        exp_q.push_back(32'h2);
        check_dout("neg1000_ovf");
        @(negedge clk);
        push4(8'hBF, 8'hBF, 8'hBF, 8'hBF);
        scan("neg1000");
    endtask

    task automatic test_restart();
        int n = 0;
        logic saw3 = 1'b0;
        write_val(16'd3);
        repeat (4) @(negedge clk);
        write_val(16'hFFFE);
        while (data_out[0] && n < 50) begin
            if (Disp === 8'hB0) saw3 = 1'b1;
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n !== 11) begin
            miscompares++;
            $display("FAIL restart busy cycles got %0d expected 11", n);
        end
        @(negedge clk);
        push4(8'hA4, 8'hFF, 8'hFF, 8'hBF);
        for (int i = 0; i < 8; i++) begin
            if (Disp === 8'hB0) saw3 = 1'b1;
            @(negedge clk);
        end
        scan("restart");
        vectors++;
        if (saw3 !== 1'b0) begin
            miscompares++;
            $display("FAIL restart stale digit got shown=1 expected shown=0");
        end
    endtask

    task automatic test_zero();
        @(negedge clk);
        write_val(16'h0000);
        wait_idle();
        exp_q.push_back(32'h0);
        check_dout("zero_status");
        push4(8'hC0, 8'hFF, 8'hFF, 8'hFF);
        scan("zero");
    endtask

    task automatic test_refresh();
        logic [3:0] prev;
        int n = 0;
        exp_q.push_back(32'hE); exp_q.push_back(32'hD); exp_q.push_back(32'hB);
        exp_q.push_back(32'h7); exp_q.push_back(32'hE);
        while (Disp_sel !== 4'b0111 && n < 40) begin n++; @(negedge clk); end
        n = 0;
        while (Disp_sel === 4'b0111 && n < 40) begin n++; @(negedge clk); end
        for (int k = 0; k < 5; k++) begin
            logic [31:0] e = exp_q.pop_front();
            prev = Disp_sel;
            vectors++;
            if (Disp_sel !== e[3:0]) begin
                miscompares++;
                $display("FAIL refresh_seq step%0d got %b expected %b", k, Disp_sel, e[3:0]);
            end
            if (k < 4) begin
                n = 0;
                while (Disp_sel === prev && n < 40) begin n++; @(negedge clk); end
                vectors++;
                if (n !== 4) begin
                    miscompares++;
                    $display("FAIL refresh_len step%0d got %0d expected 4", k, n);
                end
            end
        end
    endtask

    task automatic test_reset_during_conv();
        int n = 0;
        logic bad = 1'b0;
        @(negedge clk);
        write_val(16'd7);
        wait_idle();
        push4(8'hF8, 8'hFF, 8'hFF, 8'hFF);
        scan("seven");
        @(negedge clk);
        write_val(16'd123);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset_conv");
        @(negedge clk);
        rst = 1'b1;
        for (n = 0; n < 20; n++) begin
            if (data_out !== 32'h0) bad = 1'b1;
            if (Disp_sel === 4'b1110 && Disp !== 8'hC0) bad = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_conv stale load got 1 expected 0");
        end
        push4(8'hC0, 8'hFF, 8'hFF, 8'hFF);
        scan("reset_conv");
    endtask

    initial begin
        test_reset();
        test_negative();
        test_limits();
        test_restart();
        test_zero();
        test_refresh();
        test_reset_during_conv();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
